// File: rtl/sar_pkg.sv
// sar_pkg: FSM state encoding and width helpers shared by the SAR controller and averaging buffer
package sar_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        ACC  = 2'b01,
        PUSH = 2'b10
    } sar_state_e;

    // Accumulator width: wide enough for 2**avg_log2 full-scale samples without wrapping
    function automatic int sum_w(input int data, input int avg_log2);
        return data + avg_log2;
    endfunction

    // Occupancy width: must represent 0..depth inclusive
    function automatic int level_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sar_sync_fifo.sv
// sar_sync_fifo: first-word fall-through FIFO with occupancy count; DEPTH must be a power of two
module sar_sync_fifo #(
    parameter int DATA  = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [DATA-1:0]          data_i,
    output logic [DATA-1:0]          data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);
    localparam int AW = $clog2(DEPTH);

    logic [DATA-1:0] mem_q [DEPTH];
    logic [AW-1:0]   wr_q, rd_q;
    logic [AW:0]     lvl_q;
    logic            do_push, do_pop;

    assign full_o  = lvl_q == (AW+1)'(DEPTH);
    assign empty_o = lvl_q == '0;
    assign level_o = lvl_q;
    assign do_pop  = pop_i & ~empty_o;
    // A full FIFO still takes a write when the head leaves on the same edge
    assign do_push = push_i & (~full_o | pop_i);
    // Head is zero while empty so the output matches its reset value
    assign data_o  = empty_o ? '0 : mem_q[rd_q];

    // Storage array; contents only matter once written, so no reset
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_q] <= data_i;
    end

    // Pointers wrap naturally at the power-of-two depth
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            lvl_q <= '0;
        end else begin
            wr_q  <= wr_q + AW'(do_push);
            rd_q  <= rd_q + AW'(do_pop);
            lvl_q <= lvl_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

endmodule

// File: rtl/sar_avg_buffer.sv
// sar_avg_buffer: averages 2**AVG_LOG2 SAR conversions and queues results in a FWFT FIFO.
// Define SAR_AVG_DROPCNT_EN to add a saturating DropCount output for discarded averages.
module sar_avg_buffer
    import sar_pkg::*;
#(
    parameter int DATA     = 8,
    parameter int AVG_LOG2 = 2,
    parameter int DEPTH    = 4
) (
    input  logic                      Clock,
    input  logic                      Reset,
    input  logic                      Enable,
    input  logic                      SampleRdy,
    input  logic [DATA-1:0]           SampleIn,
    output logic                      OutValid,
    input  logic                      OutReady,
    output logic [DATA-1:0]           OutData,
    output logic [level_w(DEPTH)-1:0] Level,
    output logic                      Overrun,
`ifdef SAR_AVG_DROPCNT_EN
    output logic [15:0]               DropCount,
`endif
    input  logic                      ClearOvr
);
    localparam int SW = sum_w(DATA, AVG_LOG2);
    localparam int CW = AVG_LOG2 + 1;
    localparam logic [CW-1:0] LAST = CW'((1 << AVG_LOG2) - 1);

    sar_state_e    state_q, state_d;
    logic [SW-1:0] sum_q, sum_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          rdy_q, ovr_q, rise, push, full, empty, drop;

    assign rise     = SampleRdy & ~rdy_q;
    assign push     = state_q == PUSH;
    assign drop     = push & full & ~(OutValid & OutReady);
    assign OutValid = ~empty;
    assign Overrun  = ovr_q;

    // Window sequencing: accumulate, hand one average to the FIFO, then start a fresh window
    always_comb begin
        state_d = state_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                sum_d   = '0;
                cnt_d   = '0;
                state_d = Enable ? ACC : IDLE;
            end
            ACC: begin
                if (!Enable) begin
                    state_d = IDLE;
                    sum_d   = '0;
                    cnt_d   = '0;
                end else if (rise) begin
                    sum_d   = sum_q + SW'(SampleIn);
                    cnt_d   = cnt_q + 1'b1;
                    state_d = cnt_q == LAST ? PUSH : ACC;
                end
            end
            PUSH: begin
                state_d = Enable ? ACC : IDLE;
                sum_d   = (Enable && rise) ? SW'(SampleIn) : '0;
                cnt_d   = (Enable && rise) ? CW'(1) : '0;
            end
            default: begin
                state_d = IDLE;
                sum_d   = '0;
                cnt_d   = '0;
            end
        endcase
    end

    // State, accumulator, ready-edge history and sticky overrun (a drop beats a clear)
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            sum_q   <= '0;
            cnt_q   <= '0;
            rdy_q   <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            rdy_q   <= SampleRdy;
            ovr_q   <= drop | (ovr_q & ~ClearOvr);
        end
    end

`ifdef SAR_AVG_DROPCNT_EN
    logic [15:0] drop_cnt_q;
    assign DropCount = drop_cnt_q;

    // Saturating drop counter; an increment beats a clear in the same cycle
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) drop_cnt_q <= '0;
        else if (drop) drop_cnt_q <= drop_cnt_q == 16'hFFFF ? drop_cnt_q : drop_cnt_q + 16'd1;
        else if (ClearOvr) drop_cnt_q <= '0;
    end
`endif

    sar_sync_fifo #(.DATA(DATA), .DEPTH(DEPTH)) u_fifo (
        .clk_i   (Clock),
        .rst_i   (Reset),
        .push_i  (push),
        .pop_i   (OutReady),
        .data_i  (sum_q[SW-1:AVG_LOG2]),
        .data_o  (OutData),
        .full_o  (full),
        .empty_o (empty),
        .level_o (Level)
    );

endmodule

// File: tb/tb_sar_avg_buffer.sv
// tb_sar_avg_buffer: directed and randomized checks of sar_avg_buffer against a queue-based average model
module tb_sar_avg_buffer;
    localparam int DATA = 8, AVG_LOG2 = 2, DEPTH = 4, NS = 4;

    logic       Clock = 0, Reset = 1, Enable = 0, SampleRdy = 0, OutReady = 0, ClearOvr = 0;
    logic [7:0] SampleIn = 0;
    logic       OutValid, Overrun;
    logic [7:0] OutData;
    logic [2:0] Level;
`ifdef SAR_AVG_DROPCNT_EN
    logic [15:0] DropCount;
`endif

    sar_avg_buffer #(.DATA(DATA), .AVG_LOG2(AVG_LOG2), .DEPTH(DEPTH)) dut (
        .Clock(Clock), .Reset(Reset), .Enable(Enable), .SampleRdy(SampleRdy), .SampleIn(SampleIn),
        .OutValid(OutValid), .OutReady(OutReady), .OutData(OutData), .Level(Level), .Overrun(Overrun),
`ifdef SAR_AVG_DROPCNT_EN
        .DropCount(DropCount),
`endif
        .ClearOvr(ClearOvr)
    );

    always #5 Clock = ~Clock;

    int tests = 0, fails = 0;
    int exp_q[$];
    int cur[$];
    int ovr_m = 0, drops_m = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: every NS accepted samples form one truncated mean; a full queue drops it
    task automatic model_sample(input int v);
        int s;
        cur.push_back(v);
        if (cur.size() == NS) begin
            s = 0;
            foreach (cur[i]) s += cur[i];
            if (exp_q.size() < DEPTH) exp_q.push_back(s / NS);
            else begin
                ovr_m = 1;
                drops_m++;
            end
            cur.delete();
        end
    endtask

    task automatic samp(input int v, input int hold);
        @(negedge Clock);
        SampleIn = v[7:0];
        SampleRdy = 1;
        repeat (hold) @(negedge Clock);
        SampleRdy = 0;
        @(negedge Clock);
        model_sample(v);
    endtask

    task automatic rand_window(input int hold);
        repeat (NS) samp($urandom_range(0, 255), hold);
    endtask

    task automatic drain(input int n);
        repeat (n) begin
            check("drain_valid", OutValid, 1);
            check("drain_data", OutData, exp_q.pop_front());
            OutReady = 1;
            @(negedge Clock);
            OutReady = 0;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, OutValid, 0);
        check({tag, "_data"}, OutData, 0);
        check({tag, "_level"}, Level, 0);
        check({tag, "_ovr"}, Overrun, 0);
`ifdef SAR_AVG_DROPCNT_EN
        check({tag, "_dropcnt"}, DropCount, 0);
`endif
    endtask

    initial begin
        int v;
        #1 check_reset_outputs("reset");
        @(negedge Clock);
        Reset = 0;
        Enable = 1;
        @(negedge Clock);

        samp(10, 1); samp(20, 1); samp(30, 1);
        @(negedge Clock);
        SampleIn = 41;
        SampleRdy = 1;
        @(negedge Clock);
        SampleRdy = 0;
        check("lat_not_yet", OutValid, 0);
        @(negedge Clock);
        model_sample(41);
        check("lat_valid", OutValid, 1);
        check("avg_25", OutData, 25);
        check("lat_level", Level, 1);
        drain(1);
        check("empty_after", Level, 0);

        repeat (NS) samp(255, 1);
        check("max_no_wrap", OutData, 255);
        drain(1);
        repeat (NS) samp(0, 1);
        check("zero_valid", OutValid, 1);
        drain(1);

        rand_window(3);
        check("held_rdy_level", Level, 1);
        drain(1);
        check("held_rdy_empty", Level, 0);

        samp($urandom_range(0, 255), 1);
        samp($urandom_range(0, 255), 1);
        @(negedge Clock);
        Enable = 0;
        cur.delete();
        @(negedge Clock);
        check("disabled_level", Level, 0);
        Enable = 1;
        @(negedge Clock);
        rand_window(1);
        drain(1);

        for (int w = 0; w < 5; w++) rand_window($urandom_range(1, 2));
        check("ovr_level", Level, 4);
        check("ovr_set", Overrun, ovr_m);
`ifdef SAR_AVG_DROPCNT_EN
        check("dropcnt", DropCount, drops_m);
`endif
        @(negedge Clock);
        ClearOvr = 1;
        @(negedge Clock);
        ClearOvr = 0;
        ovr_m = 0;
        check("ovr_cleared", Overrun, ovr_m);
`ifdef SAR_AVG_DROPCNT_EN
        check("dropcnt_cleared", DropCount, 0);
`endif
        drain(4);
        check("ovr_drained", Level, 0);

        for (int w = 0; w < 4; w++) rand_window(1);
        repeat (NS - 1) samp($urandom_range(0, 255), 1);
        v = $urandom_range(0, 255);
        @(negedge Clock);
        SampleIn = v[7:0];
        SampleRdy = 1;
        @(negedge Clock);
        SampleRdy = 0;
        OutReady = 1;
        void'(exp_q.pop_front());
        @(negedge Clock);
        OutReady = 0;
        model_sample(v);
        check("fullpop_level", Level, 4);
        check("fullpop_no_ovr", Overrun, 0);
        drain(4);

        rand_window(1);
        samp($urandom_range(0, 255), 1);
        samp($urandom_range(0, 255), 1);
        check("pre_reset_valid", OutValid, 1);
        @(negedge Clock);
        #2 Reset = 1;
        #1 check_reset_outputs("async_reset");
        exp_q.delete();
        cur.delete();
        ovr_m = 0;
        drops_m = 0;
        @(negedge Clock);
        Reset = 0;
        @(negedge Clock);
        rand_window(2);
        check("post_reset_level", Level, 1);
        drain(1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
